// File: rtl/cpu_periph_pkg.sv
// Shared definitions for the CPU peripheral bus: register map, UART control
// bit positions, UART FSM state encodings and default clock/baud figures.
package cpu_periph_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 9600;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_TX_IRQ_EN  = 0;
    localparam int CON_RX_IRQ_EN  = 1;
    localparam int CON_TX_DONE    = 2;
    localparam int CON_RX_DONE    = 3;
    localparam int CON_TX_BUSY    = 4;
    localparam int CON_RX_OVERRUN = 5;
    localparam int CON_FRAME_ERR  = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate down-counter: ticks BAUD_DIV cycles after load (or BAUD_DIV/2 after
// half_load) and then every BAUD_DIV cycles until reloaded.
module uart_bit_timer
    import cpu_periph_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_CLK_HZ / DEFAULT_BAUD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic half_load,
    output logic tick
);
    localparam int W = $clog2(BAUD_DIV);
    localparam logic [W-1:0] FULL_RELOAD = W'(BAUD_DIV - 1);
    localparam logic [W-1:0] HALF_RELOAD = W'(BAUD_DIV / 2 - 1);

    logic [W-1:0] count;

    assign tick = (count == '0) && !load && !half_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= FULL_RELOAD;
        end else if (half_load) begin
            count <= HALF_RELOAD;
        end else if (count == '0) begin
            count <= FULL_RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the peripheral bus over
// independent RX and TX bit engines, with a registered completion interrupt.
module uart_mmio_ctrl
    import cpu_periph_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;

    tx_state_t   tx_state;
    rx_state_t   rx_state;
    logic [7:0]  tx_data, tx_shift, rx_data, rx_shift;
    logic [2:0]  tx_bit_cnt, rx_bit_cnt;
    logic        tx_irq_en, rx_irq_en, tx_done, rx_done, tx_busy, rx_overrun, frame_err;
    logic        rxd_meta, rxd_sync, rxd_prev;
    logic        tx_tick, rx_tick, tx_load, rx_half_load;
    logic        sel_txd, sel_rxd, sel_con, con_read, con_write, txd_write;
    logic [31:0] con_value;
    logic [23:0] unused_wdata_hi;

    assign unused_wdata_hi = wdata[31:8];

    assign sel_txd   = (addr == UART_TXD_ADDR);
    assign sel_rxd   = (addr == UART_RXD_ADDR);
    assign sel_con   = (addr == UART_CON_ADDR);
    assign con_read  = mem_read && sel_con;
    assign con_write = mem_write && sel_con;
    assign txd_write = mem_write && sel_txd;

    assign tx_load      = (tx_state == TX_IDLE) && txd_write;
    assign rx_half_load = (rx_state == RX_IDLE) && rxd_prev && !rxd_sync;

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
        .clk      (clk),
        .rst_n    (reset_b),
        .load     (tx_load),
        .half_load(1'b0),
        .tick     (tx_tick)
    );

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
        .clk      (clk),
        .rst_n    (reset_b),
        .load     (1'b0),
        .half_load(rx_half_load),
        .tick     (rx_tick)
    );

    // rxd_prev trails the synchronized line by one cycle for falling-edge detection.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
        end else if (con_write) begin
            tx_irq_en <= wdata[CON_TX_IRQ_EN];
            rx_irq_en <= wdata[CON_RX_IRQ_EN];
        end
    end

    // Read-clear comes first so a completion on the same edge overrides it.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_state   <= TX_IDLE;
            tx_data    <= '0;
            tx_shift   <= '0;
            tx_bit_cnt <= '0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            uart_txd   <= 1'b1;
        end else begin
            if (con_read) tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (txd_write) begin
                        tx_data  <= wdata[7:0];
                        tx_shift <= wdata[7:0];
                        tx_busy  <= 1'b1;
                        uart_txd <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        uart_txd   <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_cnt <= '0;
                        tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_cnt == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_txd   <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_cnt <= tx_bit_cnt + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_state   <= RX_IDLE;
            rx_data    <= '0;
            rx_shift   <= '0;
            rx_bit_cnt <= '0;
            rx_done    <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (con_read) begin
                rx_done    <= 1'b0;
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_half_load) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_bit_cnt <= '0;
                        rx_state   <= rxd_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift   <= {rxd_sync, rx_shift[7:1]};
                        rx_bit_cnt <= rx_bit_cnt + 1'b1;
                        if (rx_bit_cnt == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rxd_sync) begin
                            rx_data  <= rx_shift;
                            rx_done  <= 1'b1;
                            if (rx_done) rx_overrun <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxd_sync) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) irq <= 1'b0;
        else          irq <= (tx_irq_en && tx_done) || (rx_irq_en && rx_done);
    end

    always_comb begin
        con_value                 = '0;
        con_value[CON_TX_IRQ_EN]  = tx_irq_en;
        con_value[CON_RX_IRQ_EN]  = rx_irq_en;
        con_value[CON_TX_DONE]    = tx_done;
        con_value[CON_RX_DONE]    = rx_done;
        con_value[CON_TX_BUSY]    = tx_busy;
        con_value[CON_RX_OVERRUN] = rx_overrun;
        con_value[CON_FRAME_ERR]  = frame_err;
    end

    always_comb begin
        rdata = '0;
        if (mem_read) begin
            if (sel_txd)      rdata = {24'd0, tx_data};
            else if (sel_rxd) rdata = {24'd0, rx_data};
            else if (sel_con) rdata = con_value;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: bus reads and serial TX frames are
// checked against expectations queued from a register-level behavioural model.
module tb_uart_mmio_ctrl;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int N      = CLK_HZ / BAUD;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    logic        irq;

    uart_mmio_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int irq_rise_cyc = -1;
    logic irq_q = 1'b0;
    logic rst_seen = 1'b0;

    // Behavioural register model
    logic [7:0] m_txd = '0, m_rxd = '0;
    bit m_tx_en, m_rx_en, m_tx_done, m_rx_done, m_tx_busy, m_ovr, m_ferr;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset_b) rst_seen = 1'b1;

    always @(negedge clk) begin
        if (irq && !irq_q) irq_rise_cyc = cyc;
        irq_q = irq;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic logic [31:0] model_con();
        return {25'd0, m_ferr, m_ovr, m_tx_busy, m_rx_done, m_tx_done, m_rx_en, m_tx_en};
    endfunction

    function automatic logic [31:0] model_irq();
        return {31'd0, (m_tx_en & m_tx_done) | (m_rx_en & m_rx_done)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected read value is taken from the model at issue time; CON reads clear RC bits.
    task automatic bus_read(input string name, input logic [31:0] a);
        logic [31:0] e;
        if (a == A_TXD)      e = {24'd0, m_txd};
        else if (a == A_RXD) e = {24'd0, m_rxd};
        else if (a == A_CON) e = model_con();
        else                 e = '0;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(name);
        if (a == A_CON) begin
            m_tx_done = 0; m_rx_done = 0; m_ovr = 0; m_ferr = 0;
        end
        mem_read = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        if (a == A_TXD && !m_tx_busy) begin
            m_txd = d[7:0];
            m_tx_busy = 1;
            tx_exp_q.push_back(d[7:0]);
        end else if (a == A_CON) begin
            m_tx_en = d[0];
            m_rx_en = d[1];
        end
        mem_write = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        addr = '0;
        wdata = '0;
    endtask

    task automatic tx_finish();
        m_tx_busy = 0;
        m_tx_done = 1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input bit stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (N) @(posedge clk);
            #1;
        end
        uart_rxd = 1'b1;
    endtask

    task automatic rx_model(input logic [7:0] b, input bit stop);
        if (stop) begin
            m_ovr = m_ovr | m_rx_done;
            m_rx_done = 1;
            m_rxd = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    // Read monitor: any cycle with mem_read pops the next expectation.
    always @(negedge clk) begin
        if (mem_read) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", rdata);
            end else begin
                check_output(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
            end
        end
    end

    // Serial monitor: decodes each TX frame at mid-bit and compares to the queue.
    initial begin : tx_monitor
        logic [7:0] got;
        logic [7:0] exp_byte;
        logic       start_bit, stop_bit;
        forever begin
            @(negedge uart_txd);
            rst_seen = 1'b0;
            repeat (N / 2) @(negedge clk);
            start_bit = uart_txd;
            for (int i = 0; i < 8; i++) begin
                repeat (N) @(negedge clk);
                got[i] = uart_txd;
            end
            repeat (N) @(negedge clk);
            stop_bit = uart_txd;
            if (!rst_seen) begin
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL tx_unexpected_frame: got 0x%02h, expected no frame", got);
                end else begin
                    exp_byte = tx_exp_q.pop_front();
                    check_output("tx_frame", {22'd0, stop_bit, got, start_bit},
                                 {22'd0, 1'b1, exp_byte, 1'b0});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int s, d, lo, hi;
        logic [7:0] b, b2;
        bit stop;

        #1 reset_b = 1'b0;
        idle(3);
        reset_b = 1'b1;
        check_output("reset_txd_pin", 32'(uart_txd), 32'd1);
        check_output("reset_irq", 32'(irq), 32'd0);
        bus_read("reset_con", A_CON);
        bus_read("reset_txd", A_TXD);
        bus_read("reset_rxd", A_RXD);

        apply_stimulus(8'h0F, 1'b1); rx_model(8'h0F, 1'b1);
        idle(4);
        bus_read("rxd_frame1", A_RXD);
        idle(2 * N);
        apply_stimulus(8'h14, 1'b1); rx_model(8'h14, 1'b1);
        idle(4);
        bus_read("rxd_frame2", A_RXD);
        bus_read("unmapped", 32'h4000_0024);
        addr = A_CON;
        #1 check_output("rdata_without_read", rdata, 32'd0);
        addr = '0;
        idle(1);
        bus_read("con_overrun", A_CON);
        bus_read("con_after_clear", A_CON);

        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(2 * N);
        bus_read("con_after_glitch", A_CON);

        apply_stimulus(8'hA5, 1'b0); rx_model(8'hA5, 1'b0);
        idle(4);
        bus_read("rxd_after_frame_err", A_RXD);
        bus_read("con_frame_err", A_CON);

        bus_write(A_CON, 32'h2);
        bus_read("con_enables", A_CON);
        check_output("irq_before_rx", 32'(irq), 32'd0);
        s = cyc;
        irq_rise_cyc = -1;
        apply_stimulus(8'h3C, 1'b1); rx_model(8'h3C, 1'b1);
        idle(2);
        check_output("irq_rx", 32'(irq), model_irq());
        lo = 9 * N + N / 2;
        hi = lo + 4;
        d = (irq_rise_cyc >= 0) ? irq_rise_cyc - 1 - s : lo + 3;
        check_output("rx_done_latency_in_window", 32'((d >= lo) && (d <= hi)), 32'd1);
        if (d < lo || d > hi) d = lo + 3;
        bus_read("con_rx_irq", A_CON);
        idle(2);
        check_output("irq_cleared", 32'(irq), model_irq());

        // Read CON exactly on the edge that sets rx_done.
        fork
            apply_stimulus(8'h96, 1'b1);
            begin
                idle(d - 1);
                bus_read("con_same_cycle", A_CON);
            end
        join
        rx_model(8'h96, 1'b1);
        idle(4);
        bus_read("con_set_wins", A_CON);
        bus_write(A_CON, 32'h0);

        bus_write(A_TXD, 32'h05);
        bus_write(A_TXD, 32'hAA);
        bus_read("txd_readback", A_TXD);
        idle(10 * N - 3);
        bus_read("con_tx_busy_last_cycle", A_CON);
        tx_finish();
        bus_read("con_tx_done", A_CON);
        idle(N);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            apply_stimulus(b, stop); rx_model(b, stop);
            idle(4 + $urandom_range(0, 10));
            if ($urandom_range(0, 1) == 1) bus_read("con_rand_rx", A_CON);
            bus_read("rxd_rand", A_RXD);
        end
        bus_read("con_rand_rx_final", A_CON);

        bus_write(A_CON, 32'h1);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_write(A_TXD, {24'd0, b});
            idle(10 * N + 2);
            tx_finish();
            check_output("irq_tx", 32'(irq), model_irq());
            bus_read("con_rand_tx", A_CON);
            bus_read("txd_rand", A_TXD);
            idle(2);
            check_output("irq_tx_cleared", 32'(irq), model_irq());
        end

        b = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        fork
            bus_write(A_TXD, {24'd0, b});
            apply_stimulus(b2, 1'b1);
        join
        idle(4);
        tx_finish();
        rx_model(b2, 1'b1);
        bus_read("con_both_done", A_CON);
        bus_read("rxd_concurrent", A_RXD);

        bus_write(A_CON, 32'h2);
        apply_stimulus(8'h5A, 1'b1); rx_model(8'h5A, 1'b1);
        idle(4);
        check_output("irq_before_reset", 32'(irq), model_irq());
        bus_write(A_TXD, 32'h33);
        idle(N / 2);
        check_output("tx_start_low", 32'(uart_txd), 32'd0);
        rd_exp_q.push_back(32'd0);
        rd_name_q.push_back("con_in_reset");
        mem_read = 1'b1;
        addr = A_CON;
        #1 reset_b = 1'b0;
        #1;
        check_output("reset_async_txd", 32'(uart_txd), 32'd1);
        check_output("reset_async_irq", 32'(irq), 32'd0);
        m_txd = '0; m_rxd = '0;
        m_tx_en = 0; m_rx_en = 0; m_tx_done = 0; m_rx_done = 0;
        m_tx_busy = 0; m_ovr = 0; m_ferr = 0;
        tx_exp_q.delete();
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        addr = '0;
        idle(3);
        reset_b = 1'b1;
        idle(10 * N);
        bus_read("con_after_reset", A_CON);
        bus_read("txd_after_reset", A_TXD);
        bus_read("rxd_after_reset", A_RXD);

        bus_write(A_TXD, 32'h14);
        idle(10 * N + 2);
        tx_finish();
        bus_read("con_tx_after_reset", A_CON);
        idle(N);

        check_output("queues_drained", 32'(rd_exp_q.size() + tx_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
